// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared binary32 field widths and rounding-mode encodings for
//               the FPU converter family.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int   FP_EXP_W = 8;
    localparam int   FP_MAN_W = 23;
    localparam int   FP_BIAS  = 127;

    localparam logic RM_RNE   = 1'b0;
    localparam logic RM_RTZ   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fpu_lzc
// Description : Combinational leading-zero counter; cnt = W when x is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_lzc #(
    parameter int W = 32
) (
    input  logic [W-1:0]       x,
    output logic [$clog2(W):0] cnt,
    output logic               zero
);

    localparam int C_CW = $clog2(W) + 1;

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        cnt = C_CW'(W);
        for (int i = 0; i < W; i++) begin
            if (x[i]) begin
                cnt = C_CW'(W - 1 - i);
            end
        end
    end

    assign zero = ~|x;

endmodule
`default_nettype wire

// File: rtl/itof_pipe.sv
`default_nettype none
// ============================================================================
// Module      : itof_pipe
// Description : Three-stage integer to binary32 converter (RNE/RTZ) with
//               valid/ready handshake and sideband tag.
// Revision    : 1.0 - initial release
// ============================================================================
module itof_pipe
    import fpu_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    input  logic             in_signed,
    input  logic             in_rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_inexact,
    output logic [TAG_W-1:0] out_tag
);

    localparam int C_LZ_W = $clog2(IN_W) + 1;
    localparam int C_P_W  = 7;
    localparam int C_X_W  = IN_W + 25;

    if (IN_W < 8 || IN_W > 64) begin : g_bad_in_w
        $error("itof_pipe: IN_W must be in 8..64");
    end

    logic             w_adv;
    logic             w_sign;
    logic [IN_W-1:0]  w_mag;
    logic [C_LZ_W-1:0] w_lz;
    logic             w_zero;
    logic [IN_W-2:0]  w_norm;
    logic [C_P_W-1:0] w_p;

    logic             r_v1, r_sign1, r_rm1;
    logic [IN_W-1:0]  r_mag1;
    logic [TAG_W-1:0] r_tag1;

    logic             r_v2, r_sign2, r_rm2, r_zero2;
    logic [IN_W-2:0]  r_norm2;
    logic [C_P_W-1:0] r_p2;
    logic [TAG_W-1:0] r_tag2;

    logic [C_X_W-1:0]    w_ext;
    logic [FP_MAN_W-1:0] w_frac;
    logic                w_g, w_r, w_s, w_rnd_up, w_inexact;
    logic [FP_MAN_W:0]   w_sum;
    logic [FP_EXP_W-1:0] w_exp;
    logic [31:0]         w_y;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // S1: the negated most-negative value is exactly 2^(IN_W-1) as unsigned.
    assign w_sign = in_signed & in_x[IN_W-1];
    assign w_mag  = w_sign ? -in_x : in_x;

    // S2: the leading one is implicit, so only the bits below it are kept.
    fpu_lzc #(.W(IN_W)) u_lzc (
        .x    (r_mag1),
        .cnt  (w_lz),
        .zero (w_zero)
    );

    assign w_norm = (IN_W-1)'(r_mag1 << w_lz);
    assign w_p    = C_P_W'(IN_W - 1) - C_P_W'(w_lz);

    // S3: zero padding guarantees f, G, R and at least one sticky bit exist.
    assign w_ext     = {r_norm2, 26'd0};
    assign w_frac    = w_ext[C_X_W-1 -: FP_MAN_W];
    assign w_g       = w_ext[C_X_W-FP_MAN_W-1];
    assign w_r       = w_ext[C_X_W-FP_MAN_W-2];
    assign w_s       = |w_ext[C_X_W-FP_MAN_W-3:0];
    assign w_rnd_up  = (r_rm2 == RM_RNE) & w_g & (w_r | w_s | w_frac[0]);
    assign w_sum     = {1'b0, w_frac} + (FP_MAN_W+1)'(w_rnd_up);
    assign w_exp     = FP_EXP_W'(FP_BIAS) + FP_EXP_W'(r_p2) + FP_EXP_W'(w_sum[FP_MAN_W]);
    assign w_y       = r_zero2 ? 32'h0000_0000 : {r_sign2, w_exp, w_sum[FP_MAN_W-1:0]};
    assign w_inexact = !r_zero2 & (w_g | w_r | w_s);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1        <= 1'b0;
            r_sign1     <= 1'b0;
            r_rm1       <= 1'b0;
            r_mag1      <= '0;
            r_tag1      <= '0;
            r_v2        <= 1'b0;
            r_sign2     <= 1'b0;
            r_rm2       <= 1'b0;
            r_zero2     <= 1'b0;
            r_norm2     <= '0;
            r_p2        <= '0;
            r_tag2      <= '0;
            out_valid   <= 1'b0;
            out_y       <= '0;
            out_inexact <= 1'b0;
            out_tag     <= '0;
        end else if (w_adv) begin
            r_v1        <= in_valid;
            r_sign1     <= w_sign;
            r_rm1       <= in_rm;
            r_mag1      <= w_mag;
            r_tag1      <= in_tag;
            r_v2        <= r_v1;
            r_sign2     <= r_sign1;
            r_rm2       <= r_rm1;
            r_zero2     <= w_zero;
            r_norm2     <= w_norm;
            r_p2        <= w_p;
            r_tag2      <= r_tag1;
            out_valid   <= r_v2;
            out_y       <= w_y;
            out_inexact <= w_inexact;
            out_tag     <= r_tag2;
        end
    end

endmodule
`default_nettype wire

// File: doc/itof_pipe.md
Name: itof_pipe

Overview:
Parametrised, pipelined integer-to-IEEE-754-single converter for the FPU.
- Accepts an IN_W-bit integer, either signed (two's complement) or unsigned, selected per transaction.
- Produces a correctly rounded binary32 result with selectable rounding (nearest-even or toward-zero) and an inexact flag.
- Three-stage pipeline with a valid/ready handshake and a sideband tag, so it drops directly into the FPU issue/writeback path.

Parameters:
- IN_W, 32, input integer width; legal range 8..64.
- TAG_W, 4, width of the opaque tag carried alongside each operand (rob/register id).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  operand accepted this cycle when in_valid && in_ready.
- in_x  input  IN_W  integer operand.
- in_signed  input  1  1 = in_x is two's complement; 0 = unsigned.
- in_rm  input  1  rounding mode: 0 = round-to-nearest-even, 1 = round-toward-zero.
- in_tag  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_y  output  32  binary32 result.
- out_inexact  output  1  result != exact integer value.
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Reset (rstn low, asynchronous): all stage valid bits = 0, out_valid = 0, out_y = 0, out_inexact = 0, out_tag = 0.
  - Reset mid-operation discards all in-flight operands; no partial result emerges after release.
- Pipeline advance: adv = !out_valid || out_ready, and in_ready = adv.
  - The whole pipeline moves together or holds together; no bubble squeezing.
  - While held, every stage register, out_y, out_inexact and out_tag stay stable.
- Latency: exactly 3 clk edges from acceptance to out_valid when adv stays high. Throughput is 1 per cycle.
  - Accept and emit in the same cycle is legal.
  - Bubbles (in_valid = 0 on an adv cycle) propagate as valid = 0.
- S1 (capture/abs):
  - sign = in_signed & in_x[IN_W-1].
  - mag = sign ? -in_x : in_x, computed as an IN_W-bit unsigned magnitude, so the most negative signed value yields 2^(IN_W-1) exactly.
  - Register sign, mag, rm, tag.
- S2 (normalise):
  - p = index of the most significant 1 in mag, from the fpu_lzc count.
  - norm = mag shifted left so bit p lands at the top bit.
  - zero = (mag == 0).
- S3 (round/pack):
  - Fraction f = 23 bits below the leading 1, zero-filled when p < 23.
  - Discarded bits: G = first bit below f, R = second bit below, S = OR of all further bits.
  - inexact = G|R|S.
  - RNE: round up iff G & (R | S | f[0]). RTZ: never round up.
  - Round-up carry out of f sets f = 0 and increments the exponent.
  - Exponent = 127 + p (+1 on carry). Maximum is 127 + 64 = 191, so overflow and infinity cannot occur.
  - out_y = {sign, exp[7:0], f}.
  - zero input: out_y = 32'h0000_0000 (+0, never -0), inexact = 0.
- No special-case constants for all-ones or other inputs: every value follows the general path.
- Unused/illegal parameter values (IN_W outside 8..64) fail elaboration via an initial check.

Decomposition:
- Shared package fpu_pkg:
  - FP_EXP_W = 8, FP_MAN_W = 23, FP_BIAS = 127.
  - Rounding-mode encoding constants RM_RNE = 1'b0, RM_RTZ = 1'b1, shared with the other FPU converters.
- One sub-module: fpu_lzc.
  - Parametrised leading-zero counter: input width W, output count of $clog2(W)+1 bits, plus an all-zero flag.
  - Purely combinational; instantiated in S2 and reusable by ftoi and fadd normalisation.

Test Plan:
- IN_W=32, signed, RNE, in_x=32'hFFFF_FFFF (-1) -> out_y=32'hBF80_0000, inexact=0, exactly 3 cycles after acceptance.
- Signed RNE 32'h7FFF_FFFF -> 32'h4F00_0000, inexact=1. Signed 32'h8000_0000 -> 32'hCF00_0000, inexact=0.
- Unsigned 32'hFFFF_FFFF: RNE -> 32'h4F80_0000, inexact=1; RTZ -> 32'h4F7F_FFFF, inexact=1.
- Ties, unsigned RNE: 32'h0100_0001 -> 32'h4B80_0000 (tie to even, down); 32'h0100_0003 -> 32'h4B80_0002 (tie to even, up); both inexact=1.
- Back-to-back stream of 8 operands with out_ready toggled 1,0,0,1,... and in_x=0 included:
  - all results emerge in order with correct tags;
  - outputs are stable while held;
  - zero gives 32'h0 with inexact=0;
  - in_ready mirrors adv.
- rstn pulsed low with 3 operands in flight -> out_valid=0 immediately (asynchronously) and no stale result appears after release. Repeat with IN_W=16 and IN_W=64 on a random-vs-model sweep.
